// File: rtl/edsac_store_pkg.sv
// edsac_store_pkg: shared store geometry and rack FSM states
package edsac_store_pkg;
  localparam int WORD_BITS = 36;
  localparam int WORDS = 16;
  localparam int TANKS = 8;
  typedef enum logic [2:0] {IDLE, WAIT, XFER, DONE, CLEAR} state_t;
endpackage

// File: rtl/tank_rack_if.sv
// tank_rack_if: control-side request/serial-data bus of one store rack
interface tank_rack_if;
  logic rack_read;
  logic rack_write;
  logic [2:0] tank_sel;
  logic [3:0] word_addr;
  logic wr_bit;
  logic rd_bit;
  logic rd_valid;
  logic wr_ready;
  logic busy;
  logic done;
  logic [5:0] bit_pos;
  logic [3:0] word_pos;
  modport master (
    output rack_read, rack_write, tank_sel, word_addr, wr_bit,
    input rd_bit, rd_valid, wr_ready, busy, done, bit_pos, word_pos
  );
  modport slave (
    input rack_read, rack_write, tank_sel, word_addr, wr_bit,
    output rd_bit, rd_valid, wr_ready, busy, done, bit_pos, word_pos
  );
endinterface

// File: rtl/tank_timer.sv
// tank_timer: free-running bit/word circulation counters; hit flags that addr's slot starts next cycle
module tank_timer #(
  parameter int WORD_BITS = 36,
  parameter int WORDS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [$clog2(WORDS)-1:0] addr,
  output logic [$clog2(WORD_BITS)-1:0] bit_pos,
  output logic [$clog2(WORDS)-1:0] word_pos,
  output logic last_bit,
  output logic hit
);
  localparam int BW = $clog2(WORD_BITS);
  localparam int WW = $clog2(WORDS);
  logic last_word;
  logic [WW-1:0] word_next;
  assign last_bit = bit_pos == BW'(WORD_BITS - 1);
  assign last_word = word_pos == WW'(WORDS - 1);
  assign word_next = last_word ? '0 : word_pos + 1'b1;
  assign hit = last_bit && word_next == addr;
  // bit counter runs every clock; word counter steps on each bit wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bit_pos <= '0;
      word_pos <= '0;
    end else begin
      bit_pos <= last_bit ? '0 : bit_pos + 1'b1;
      if (last_bit) word_pos <= word_next;
    end
endmodule

// File: rtl/tank_rack.sv
// tank_rack: bit-serial read/write responder for one rack of delay-line tanks
// Define TANK_RACK_CLEAR_ON_RESET_EN to zero every word in a CLEAR sweep after reset.
module tank_rack
  import edsac_store_pkg::*;
#(
  parameter int WORD_BITS = edsac_store_pkg::WORD_BITS,
  parameter int WORDS = edsac_store_pkg::WORDS,
  parameter int TANKS = edsac_store_pkg::TANKS
) (
  input logic clk,
  input logic rst_n,
  tank_rack_if.slave bus
);
  localparam int IW = $clog2(TANKS * WORDS);
  localparam int WW = $clog2(WORDS);
`ifdef TANK_RACK_CLEAR_ON_RESET_EN
  localparam state_t RST_STATE = CLEAR;
`else
  localparam state_t RST_STATE = IDLE;
`endif
  state_t state, state_next;
  logic [WORD_BITS-1:0] mem [TANKS*WORDS];
  logic [WORD_BITS-1:0] sh;
  logic [IW-1:0] idx, idx_next, clr;
  logic wr, req, hit, last_bit;
  assign req = bus.rack_read | bus.rack_write;
  assign idx_next = state == IDLE ? {bus.tank_sel, bus.word_addr} : idx;
  tank_timer #(.WORD_BITS(WORD_BITS), .WORDS(WORDS)) timer (
    .clk(clk),
    .rst_n(rst_n),
    .addr(idx_next[WW-1:0]),
    .bit_pos(bus.bit_pos),
    .word_pos(bus.word_pos),
    .last_bit(last_bit),
    .hit(hit)
  );
  // next state: enter XFER exactly as the addressed slot reaches bit 0
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = req ? (hit ? XFER : WAIT) : IDLE;
      WAIT:    state_next = hit ? XFER : WAIT;
      XFER:    state_next = last_bit ? DONE : XFER;
      DONE:    state_next = IDLE;
      CLEAR:   state_next = clr == IW'(TANKS * WORDS - 1) ? IDLE : CLEAR;
      default: state_next = IDLE;
    endcase
  end
  // state, request latch, clear sweep index and serial shift register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RST_STATE;
      idx <= '0;
      wr <= 1'b0;
      sh <= '0;
      clr <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req) begin
        idx <= idx_next;
        wr <= bus.rack_write;
      end
      if (state != XFER && state_next == XFER) sh <= mem[idx_next];
      else if (state == XFER) sh <= {wr & bus.wr_bit, sh[WORD_BITS-1:1]};
      if (state == CLEAR) clr <= clr + 1'b1;
    end
  // commit a complete write word on the last bit, or zero one word per clock while clearing
  always_ff @(posedge clk)
    if (state == XFER && wr && last_bit) mem[idx] <= {bus.wr_bit, sh[WORD_BITS-1:1]};
    else if (state == CLEAR) mem[clr] <= '0;
  assign bus.rd_valid = state == XFER && !wr;
  assign bus.wr_ready = state == XFER && wr;
  assign bus.rd_bit = bus.rd_valid & sh[0];
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
endmodule

// File: tb/tb_tank_rack.sv
// tb_tank_rack: table, directed and randomized checks of tank_rack against a slot-timing model
module tb_tank_rack;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  tank_rack_if bus();
  tank_rack dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
`ifdef TANK_RACK_CLEAR_ON_RESET_EN
  localparam bit BUSY_RST = 1'b1;
  localparam logic [35:0] RMW_WANT = 36'h0;
`else
  localparam bit BUSY_RST = 1'b0;
  localparam logic [35:0] RMW_WANT = 36'h1;
`endif
  typedef struct {
    bit wr;
    bit both;
    int tank;
    int word;
    logic [35:0] data;
    logic [35:0] want;
  } vec_t;
  int cyc;
  int errors = 0;
  int checks = 0;
  logic [35:0] model [128];
  bit known [128];
  // absolute bit-time since reset; slot position is just cyc modulo the major cycle
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask
  task automatic idle_bus;
    bus.rack_read = 1'b0;
    bus.rack_write = 1'b0;
    bus.wr_bit = 1'b0;
  endtask
  task automatic do_reset;
    int n;
    rst_n = 1'b0;
    idle_bus();
    repeat (2) @(negedge clk);
    chk("rst_outputs", {bus.rd_bit, bus.rd_valid, bus.wr_ready, bus.done, bus.bit_pos, bus.word_pos}, 64'h0);
    chk("rst_busy", bus.busy, BUSY_RST);
    rst_n = 1'b1;
    n = 0;
`ifdef TANK_RACK_CLEAR_ON_RESET_EN
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 300);
    chk("clear_len", n, 128);
    for (int i = 0; i < 128; i++) begin
      model[i] = '0;
      known[i] = 1'b1;
    end
`endif
  endtask
  // one request issued at the current negedge; expected latency from slot arithmetic
  task automatic xact(input bit wr, input bit both, input int tank, input int word,
                      input logic [35:0] data, output logic [35:0] got, output int lat);
    int c, exp_lat, n, idx;
    bit w;
    w = wr | both;
    idx = tank * 16 + word;
    c = cyc % 576;
    exp_lat = ((word * 36 - c - 1 + 576) % 576) + 1;
    bus.rack_read = !wr | both;
    bus.rack_write = w;
    bus.tank_sel = 3'(tank);
    bus.word_addr = 4'(word);
    bus.wr_bit = 1'b0;
    @(negedge clk);
    bus.rack_read = 1'b0;
    bus.rack_write = 1'b0;
    n = 1;
    while (!(bus.rd_valid || bus.wr_ready) && n < 600) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    chk("latency", n, exp_lat);
    got = '0;
    for (int k = 0; k < 36; k++) begin
      chk("xfer_dir", {bus.rd_valid, bus.wr_ready}, w ? 2'b01 : 2'b10);
      chk("xfer_slot", {bus.word_pos, bus.bit_pos}, {4'(word), 6'(k)});
      if (w) bus.wr_bit = data[k];
      else got[k] = bus.rd_bit;
      @(negedge clk);
    end
    bus.wr_bit = 1'b0;
    chk("done_pulse", {bus.done, bus.busy, bus.rd_valid, bus.wr_ready}, 4'b1100);
    @(negedge clk);
    chk("done_end", {bus.done, bus.busy}, 2'b00);
    if (w) begin
      model[idx] = data;
      known[idx] = 1'b1;
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t vt[10];
    logic [35:0] got, pm;
    int lat, n, rdv, wrr, tank, word, idx;
    bit wr, pre;
    vt[0] = '{1'b1, 1'b0, 3, 5, 36'h9_8765_4321, 36'h0};
    vt[1] = '{1'b0, 1'b0, 3, 5, 36'h0, 36'h9_8765_4321};
    vt[2] = '{1'b0, 1'b1, 7, 15, 36'hF_FFFF_FFFF, 36'h0};
    vt[3] = '{1'b0, 1'b0, 7, 15, 36'h0, 36'hF_FFFF_FFFF};
    vt[4] = '{1'b1, 1'b0, 0, 0, 36'h8_0000_0001, 36'h0};
    vt[5] = '{1'b0, 1'b0, 0, 0, 36'h0, 36'h8_0000_0001};
    vt[6] = '{1'b1, 1'b0, 4, 6, 36'h1, 36'h0};
    vt[7] = '{1'b0, 1'b0, 4, 6, 36'h0, 36'h1};
    vt[8] = '{1'b1, 1'b0, 1, 2, 36'hA_5A5A_5A5A, 36'h0};
    vt[9] = '{1'b0, 1'b0, 1, 2, 36'h0, 36'hA_5A5A_5A5A};
    for (int i = 0; i < 128; i++) known[i] = 1'b0;
    idle_bus();
    bus.tank_sel = '0;
    bus.word_addr = '0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      xact(vt[i].wr, vt[i].both, vt[i].tank, vt[i].word, vt[i].data, got, lat);
      if (!vt[i].wr && !vt[i].both) chk("table_read", got, vt[i].want);
    end
    n = 0;
    while (cyc % 576 != 0 && n < 700) begin
      @(negedge clk);
      n++;
    end
    xact(1'b0, 1'b0, 0, 0, 36'h0, got, lat);
    chk("wrap_latency", lat, 576);
    chk("wrap_data", got, 36'h8_0000_0001);
    n = 0;
    while (cyc % 576 != 122 && n < 700) begin
      @(negedge clk);
      n++;
    end
    bus.rack_read = 1'b1;
    bus.tank_sel = 3'd1;
    bus.word_addr = 4'd2;
    @(negedge clk);
    idle_bus();
    repeat (5) @(negedge clk);
    chk("rej_busy", bus.busy, 1'b1);
    bus.rack_write = 1'b1;
    bus.wr_bit = 1'b1;
    @(negedge clk);
    bus.rack_write = 1'b0;
    n = 0;
    rdv = 0;
    wrr = 0;
    while (bus.busy && n < 700) begin
      rdv += int'(bus.rd_valid);
      wrr += int'(bus.wr_ready);
      @(negedge clk);
      n++;
    end
    bus.wr_bit = 1'b0;
    chk("rej_wr_ready", wrr, 0);
    chk("rej_rd_valid", rdv, 36);
    xact(1'b0, 1'b0, 1, 2, 36'h0, got, lat);
    chk("rej_data", got, 36'hA_5A5A_5A5A);
    bus.rack_write = 1'b1;
    bus.tank_sel = 3'd4;
    bus.word_addr = 4'd6;
    @(negedge clk);
    bus.rack_write = 1'b0;
    n = 1;
    while (!bus.wr_ready && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("rmw_start", bus.wr_ready, 1'b1);
    for (int k = 0; k < 20; k++) begin
      bus.wr_bit = 1'b0;
      @(negedge clk);
    end
    chk("rmw_pos", {bus.word_pos, bus.bit_pos}, {4'd6, 6'd20});
    rst_n = 1'b0;
    #1;
    chk("rmw_outputs", {bus.rd_bit, bus.rd_valid, bus.wr_ready, bus.done, bus.bit_pos, bus.word_pos}, 64'h0);
    chk("rmw_busy", bus.busy, BUSY_RST);
    do_reset();
    xact(1'b0, 1'b0, 4, 6, 36'h0, got, lat);
    chk("rmw_data", got, RMW_WANT);
    xact(1'b0, 1'b0, 2, 9, 36'h0, got, lat);
`ifdef TANK_RACK_CLEAR_ON_RESET_EN
    chk("clear_word", got, 36'h0);
`endif
    for (int r = 0; r < 24; r++) begin
      repeat ($urandom_range(0, 40)) @(negedge clk);
      wr = 1'($urandom_range(0, 1));
      tank = int'($urandom_range(5, 6));
      word = int'($urandom_range(0, 3));
      idx = tank * 16 + word;
      pre = known[idx];
      pm = model[idx];
      xact(wr, 1'b0, tank, word, {4'($urandom), $urandom}, got, lat);
      if (!wr && pre) chk("rand_read", got, pm);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tank_rack.md
# tank_rack

Bit-serial responder for one rack of mercury-delay-line memory (8 tanks × 16 words × 36 bits), driven by the rack read/write selects from first-stage tank decoding. It emulates circulation with free-running minor-cycle counters. It waits for the addressed word to reach the tank output, then streams that word out (read) or replaces it with incoming serial data (write). Four instances (F1, F2, R1, R2) sit between the control section and the store bus.

## Interface
Parameters:
- WORD_BITS, 36, bits per long word (one minor cycle = WORD_BITS clocks)
- WORDS, 16, words per tank (one major cycle = WORDS minor cycles)
- TANKS, 8, tanks per rack

Ports:
- clk  in  1  system clock, one bit-time per cycle
- rst_n  in  1  asynchronous, active-low reset
- rack_read  in  1  read select for this rack (one-cycle pulse)
- rack_write  in  1  write select for this rack (one-cycle pulse)
- tank_sel  in  3  tank within rack, sampled with request
- word_addr  in  4  word within tank, sampled with request
- wr_bit  in  1  serial write data, LSB first
- rd_bit  out  1  serial read data, LSB first
- rd_valid  out  1  rd_bit valid
- wr_ready  out  1  wr_bit is sampled this cycle
- busy  out  1  request in progress or clear sweep running
- done  out  1  one-cycle completion pulse
- bit_pos  out  6  current bit-time (0..WORD_BITS-1)
- word_pos  out  4  current word slot (0..WORDS-1)

## Operation
- Counters: bit_pos increments every cycle and wraps WORD_BITS-1→0. word_pos increments when bit_pos wraps, and wraps WORDS-1→0. All tanks share these counters.
- Requests are accepted only in IDLE. A request arriving while busy=1 is ignored; no queueing.
- If rack_read and rack_write are both high, write wins.
- FSM:
  - IDLE: on request, latch tank_sel, word_addr and direction, then go to WAIT.
  - WAIT: on coincidence (word_pos==latched addr and bit_pos==0), go to XFER.
  - XFER: lasts exactly WORD_BITS cycles, then go to DONE.
  - DONE: one cycle, done=1, then go to IDLE.
- Read: in XFER cycle k (k=0..35, equal to bit_pos), rd_valid=1 and rd_bit=word[k]. Storage is unchanged.
- Write: in XFER cycle k, wr_ready=1 and wr_bit is captured as bit k. The full word commits to storage at the clock edge ending the last XFER cycle. Nothing is committed earlier.
- busy=1 in WAIT, XFER, DONE (and CLEAR, if built).

## Timing
- Reset values: rd_bit=0, rd_valid=0, wr_ready=0, busy=0, done=0, bit_pos=0, word_pos=0, FSM=IDLE (or CLEAR, see below).
- The request is sampled at edge N. Coincidence is evaluated from cycle N+1. If the counters sit at the coincidence in cycle N, the transfer waits a full major cycle (576 clocks).
- Latency from request edge to first XFER cycle: 1..576 cycles. done is asserted WORD_BITS cycles after the first XFER cycle.
- The earliest new request is accepted in the cycle after done.
- Reset mid-transfer: FSM returns to IDLE immediately. A partially received write word is discarded. Stored contents are otherwise untouched.

## Configuration
- TANK_RACK_CLEAR_ON_RESET_EN defined:
  - After rst_n deasserts, the FSM enters CLEAR and writes zero to all TANKS×WORDS words, one per cycle (128 cycles).
  - busy=1 throughout CLEAR. Requests are ignored. Then go to IDLE.
  - Counters run normally during CLEAR.
- Undefined: the FSM resets to IDLE. Storage contents after power-up are unspecified; after a later reset they are retained.

## Structure
- Shared package edsac_store_pkg:
  - WORD_BITS, WORDS, TANKS constants.
  - FSM state enum (IDLE, WAIT, XFER, DONE, CLEAR).
- Sub-module tank_timer: bit_pos/word_pos counters plus a coincidence compare. It is reused by other store-side blocks.
- Storage is an inferred array [TANKS*WORDS][WORD_BITS] indexed {tank_sel, word_addr}. A shift register serves serial in/out.

## Test plan
- Write then read: write tank 3, word 5 with 36'h9_8765_4321. Read it back: rd_bit stream LSB first reproduces 36'h9_8765_4321 with rd_valid high during word_pos=5. Exactly 36 valid cycles, then one done pulse.
- Coincidence wrap: issue a read of word 0 at the edge where word_pos=0, bit_pos=0. The first rd_valid occurs 576 cycles later.
- Busy rejection: issue a read, then a write pulse during WAIT. The write is ignored and the target word is unchanged.
- Simultaneous selects: rack_read=rack_write=1 targeting tank 7, word 15 with wr_bit=1 throughout. The word reads back as 36'hF_FFFF_FFFF.
- Reset mid-write: assert rst_n=0 at XFER cycle 20 of a write of 0 over a word holding 36'h1. Outputs return to reset values, and the word still reads 36'h1 (macro undefined).
- Clear build: with TANK_RACK_CLEAR_ON_RESET_EN, busy stays high 128 cycles after reset. A subsequent read of tank 2, word 9 returns 0.
